// File: rtl/uart_tx_ctrl.sv
// UART transmit control engine.
// Sits directly upstream of the 11-bit TX shift register. A host byte write is latched
// together with its frame configuration. The engine then pulses the register's load strobe,
// presents the data and frame bits, and paces one shift strobe per bit time. When the last
// bit has been shifted, it reports ready again and raises a one-cycle interrupt.
//
// Expected shift register image at load: {bit10, bit9, din[6:0], 1'b0 (start), 1'b1 (mark)},
// shifted LSB first.

module uart_tx_ctrl #(
  parameter int unsigned BAUD_W     = 20,
  parameter int unsigned FRAME_BITS = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [7:0]        out_port,
  input  logic              eight,
  input  logic              pen,
  input  logic              ohel,
  input  logic [BAUD_W-1:0] baud_k,
  output logic              ld,
  output logic              sh,
  output logic [6:0]        din,
  output logic              bit9,
  output logic              bit10,
  output logic              tx_rdy,
  output logic              tx_int
);

  localparam int unsigned CNT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    StIdle,   // waiting for a byte write
    StLoad,   // ld is high, the shift register captures the frame at the next edge
    StShift   // bit timer running, one sh per bit time
  } state_e;

  state_e            state_q;
  logic              doit_q;
  logic [BAUD_W-1:0] timer_q;
  logic [CNT_W-1:0]  bit_cnt_q;

  logic [7:0]        data_q;
  logic              eight_q;
  logic              pen_q;
  logic              ohel_q;

  logic              accept;
  logic              btu;
  logic              last_bit;
  logic              parity;

  // A write is only taken while idle; a write in any other cycle is dropped on the floor.
  assign accept = load & tx_rdy;

  // Bit-time boundary. baud_k is read live, so software must only change it while idle.
  assign btu = doit_q & (timer_q == baud_k);

  // The final shift of the frame; completes the transmission at the next edge.
  assign last_bit = btu & (bit_cnt_q == LAST_BIT);

  // Sequencing FSM with registered ld / doit / tx_rdy / tx_int.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ld      <= 1'b0;
      doit_q  <= 1'b0;
      tx_rdy  <= 1'b1;
      tx_int  <= 1'b0;
    end else begin
      ld     <= 1'b0;
      tx_int <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            state_q <= StLoad;
            ld      <= 1'b1;
            tx_rdy  <= 1'b0;
          end
        end
        StLoad: begin
          state_q <= StShift;
          doit_q  <= 1'b1;
        end
        StShift: begin
          if (last_bit) begin
            state_q <= StIdle;
            doit_q  <= 1'b0;
            tx_rdy  <= 1'b1;
            tx_int  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          doit_q  <= 1'b0;
          tx_rdy  <= 1'b1;
        end
      endcase
    end
  end

  // Data and frame configuration are captured only on an accepted write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= 8'h00;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
    end else if (accept) begin
      data_q  <= out_port;
      eight_q <= eight;
      pen_q   <= pen;
      ohel_q  <= ohel;
    end
  end

  // Bit-time counter: free runs during a frame, wraps at baud_k, parked at 0 otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else if (!doit_q || btu) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + BAUD_W'(1);
    end
  end

  // Shift counter: one count per bit time, cleared when the frame completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt_q <= '0;
    end else if (!doit_q || last_bit) begin
      bit_cnt_q <= '0;
    end else if (btu) begin
      bit_cnt_q <= bit_cnt_q + CNT_W'(1);
    end
  end

  // Parity over the active data bits, inverted for odd sense.
  always_comb begin
    parity = eight_q ? ^data_q : ^data_q[6:0];
    parity = parity ^ ohel_q;
  end

  // Frame-bit decode from latched configuration; unused positions carry stop (mark) bits.
  always_comb begin
    bit9  = 1'b1;
    bit10 = 1'b1;
    unique case ({eight_q, pen_q})
      2'b11: begin
        bit9  = data_q[7];
        bit10 = parity;
      end
      2'b10: begin
        bit9  = data_q[7];
        bit10 = 1'b1;
      end
      2'b01: begin
        bit9  = parity;
        bit10 = 1'b1;
      end
      2'b00: begin
        bit9  = 1'b1;
        bit10 = 1'b1;
      end
      default: begin
        bit9  = 1'b1;
        bit10 = 1'b1;
      end
    endcase
  end

  // Data bits and shift strobe go straight to the shift register.
  always_comb begin
    din = data_q[6:0];
    sh  = btu;
  end

  // Structural invariants of the handshake.
  ld_one_cycle: assert property (@(posedge clk) disable iff (reset) ld |=> !ld);
  int_one_cycle: assert property (@(posedge clk) disable iff (reset) tx_int |=> !tx_int);
  sh_only_busy: assert property (@(posedge clk) disable iff (reset) sh |-> !tx_rdy);
  ld_before_shift: assert property (@(posedge clk) disable iff (reset) ld |-> !doit_q);

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl. A downstream shift register is modelled from the
// DUT's ld/sh/din/bit9/bit10, and the serial stream it produces is compared against a frame
// built from the transmitted byte and configuration.

module tb_uart_tx_ctrl;

  logic        clk;
  logic        reset;
  logic        load;
  logic [7:0]  out_port;
  logic        eight;
  logic        pen;
  logic        ohel;
  logic [19:0] baud_k;
  logic        ld;
  logic        sh;
  logic [6:0]  din;
  logic        bit9;
  logic        bit10;
  logic        tx_rdy;
  logic        tx_int;

  int n_checks;
  int n_fail;

  // Observations from the most recent frame.
  int          obs_sh[$];
  logic [10:0] obs_stream;
  int          obs_nsh;
  int          obs_latency;
  int          obs_int;
  int          obs_ld;
  int          obs_ld_first;
  int          obs_post_bad;
  logic        obs_rdy0;
  logic [6:0]  obs_din_ld;
  logic        obs_b9_ld;
  logic        obs_b10_ld;
  logic [6:0]  obs_din_end;
  logic        obs_b9_end;
  logic        obs_b10_end;

  uart_tx_ctrl #(
    .BAUD_W     (20),
    .FRAME_BITS (11)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .out_port (out_port),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
    .baud_k   (baud_k),
    .ld       (ld),
    .sh       (sh),
    .din      (din),
    .bit9     (bit9),
    .bit10    (bit10),
    .tx_rdy   (tx_rdy),
    .tx_int   (tx_int)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic ref_parity(input logic [7:0] d, input logic e, input logic o);
    int ones;
    ones = 0;
    for (int i = 0; i < (e ? 8 : 7); i++) ones += int'(d[i]);
    return logic'(ones % 2) ^ o;
  endfunction

  function automatic logic ref_bit9(input logic [7:0] d, input logic e, input logic p,
                                    input logic o);
    if (e) return d[7];
    if (p) return ref_parity(d, e, o);
    return 1'b1;
  endfunction

  function automatic logic ref_bit10(input logic [7:0] d, input logic e, input logic p,
                                     input logic o);
    if (e && p) return ref_parity(d, e, o);
    return 1'b1;
  endfunction

  // Line bits in the order they leave the shift register: mark, start, 7 data LSB first, 9, 10.
  function automatic logic [10:0] ref_frame(input logic [7:0] d, input logic e, input logic p,
                                            input logic o);
    logic [10:0] f;
    f[0] = 1'b1;
    f[1] = 1'b0;
    for (int i = 0; i < 7; i++) f[2+i] = d[i];
    f[9]  = ref_bit9(d, e, p, o);
    f[10] = ref_bit10(d, e, p, o);
    return f;
  endfunction

  // Issue one write and follow the frame to completion. inj_at >= 0 drives a second write
  // (with new data and inverted config) during observation cycle inj_at.
  task automatic run_frame(input logic [7:0] d, input logic e, input logic p, input logic o,
                           input logic [19:0] bk, input int inj_at, input logic [7:0] inj_d);
    logic [10:0] sr;
    int          budget;
    obs_sh.delete();
    obs_stream   = '0;
    obs_nsh      = 0;
    obs_latency  = -1;
    obs_int      = 0;
    obs_ld       = 0;
    obs_ld_first = -1;
    obs_post_bad = 0;
    sr           = '1;
    baud_k   = bk;
    out_port = d;
    eight    = e;
    pen      = p;
    ohel     = o;
    load     = 1'b1;
    tick();
    load     = 1'b0;
    obs_rdy0 = tx_rdy;
    budget   = 11 * (int'(bk) + 1) + 20;
    for (int c = 0; c < budget; c++) begin
      if (ld) begin
        obs_ld++;
        if (obs_ld_first < 0) obs_ld_first = c;
        obs_din_ld = din;
        obs_b9_ld  = bit9;
        obs_b10_ld = bit10;
      end
      if (tx_int) obs_int++;
      if (c > 0 && tx_rdy) begin
        obs_latency = c;
        obs_din_end = din;
        obs_b9_end  = bit9;
        obs_b10_end = bit10;
        break;
      end
      if (sh) begin
        if (obs_nsh < 11) obs_stream[obs_nsh] = sr[0];
        obs_nsh++;
        obs_sh.push_back(c);
      end
      if (ld) sr = {bit10, bit9, din, 1'b0, 1'b1};
      else if (sh) sr = {1'b1, sr[10:1]};
      if (c == inj_at) begin
        load     = 1'b1;
        out_port = inj_d;
        eight    = ~e;
        pen      = ~p;
        ohel     = ~o;
      end else begin
        load = 1'b0;
      end
      tick();
    end
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ld || sh || !tx_rdy) obs_post_bad++;
      if (tx_int) obs_int++;
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    load     = 1'b0;
    out_port = 8'h00;
    eight    = 1'b0;
    pen      = 1'b0;
    ohel     = 1'b0;
    baud_k   = 20'd3;
    repeat (3) tick();
    n_checks++;
    if ({ld, sh, tx_rdy, tx_int} !== 4'b0010) begin
      n_fail++;
      $display("FAIL reset_outputs: got ld/sh/rdy/int=%b required 0010", {ld, sh, tx_rdy, tx_int});
    end
    n_checks++;
    if ({din, bit9, bit10} !== 9'b0000000_11) begin
      n_fail++;
      $display("FAIL reset_frame_bits: got din=%h b9=%b b10=%b required 00 1 1", din, bit9, bit10);
    end
    reset = 1'b0;
  endtask

  task automatic test_idle();
    int bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      out_port = 8'($urandom);
      eight    = 1'($urandom);
      pen      = 1'($urandom);
      baud_k   = 20'($urandom_range(0, 3));
      tick();
      if (ld || sh || tx_int || !tx_rdy || din !== 7'h00) bad++;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL idle_no_activity: got %0d active cycles required 0", bad);
    end
  endtask

  task automatic test_basic_frame();
    int bad;
    run_frame(8'hA5, 1'b1, 1'b0, 1'($urandom), 20'd3, -1, 8'h00);
    n_checks++;
    if (obs_rdy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_rdy_drop: got tx_rdy=%b after accept required 0", obs_rdy0);
    end
    n_checks++;
    if (obs_ld != 1 || obs_ld_first != 0) begin
      n_fail++;
      $display("FAIL basic_ld_pulse: got %0d cycles first at %0d required 1 at 0",
               obs_ld, obs_ld_first);
    end
    bad = 0;
    foreach (obs_sh[k]) if (obs_sh[k] != (k + 1) * 4) bad++;
    n_checks++;
    if (obs_nsh != 11 || bad != 0) begin
      n_fail++;
      $display("FAIL basic_sh_pacing: got %0d pulses %0d misplaced required 11 every 4 clocks",
               obs_nsh, bad);
    end
    n_checks++;
    if (obs_stream !== 11'b11010010101) begin
      n_fail++;
      $display("FAIL basic_stream: got %b required 11010010101", obs_stream);
    end
    n_checks++;
    if (obs_latency != 45) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d required 45", obs_latency);
    end
    n_checks++;
    if (obs_int != 1) begin
      n_fail++;
      $display("FAIL basic_tx_int: got %0d pulse cycles required 1", obs_int);
    end
  endtask

  task automatic test_parity();
    logic [2:0]  cfg [3];
    logic [1:0]  want [3];
    cfg[0] = 3'b110; want[0] = 2'b01;  // eight pen ohel -> bit9 bit10
    cfg[1] = 3'b111; want[1] = 2'b00;
    cfg[2] = 3'b010; want[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      run_frame(8'h07, cfg[i][2], cfg[i][1], cfg[i][0], 20'd1, -1, 8'h00);
      n_checks++;
      if ({obs_b9_ld, obs_b10_ld} !== want[i]) begin
        n_fail++;
        $display("FAIL parity_bits_%0d: got b9b10=%b required %b", i, {obs_b9_ld, obs_b10_ld},
                 want[i]);
      end
      n_checks++;
      if (obs_stream !== ref_frame(8'h07, cfg[i][2], cfg[i][1], cfg[i][0])) begin
        n_fail++;
        $display("FAIL parity_stream_%0d: got %b required %b", i, obs_stream,
                 ref_frame(8'h07, cfg[i][2], cfg[i][1], cfg[i][0]));
      end
    end
  endtask

  task automatic test_midframe_load();
    logic [7:0] d;
    logic       o;
    d = 8'($urandom);
    o = 1'($urandom);
    run_frame(d, 1'b1, 1'b1, o, 20'd2, 10, 8'h3C);
    n_checks++;
    if ({obs_din_end, obs_b9_end, obs_b10_end} !==
        {d[6:0], ref_bit9(d, 1'b1, 1'b1, o), ref_bit10(d, 1'b1, 1'b1, o)}) begin
      n_fail++;
      $display("FAIL midload_latch: got din=%h b9=%b b10=%b required din=%h b9=%b b10=%b",
               obs_din_end, obs_b9_end, obs_b10_end, d[6:0], ref_bit9(d, 1'b1, 1'b1, o),
               ref_bit10(d, 1'b1, 1'b1, o));
    end
    n_checks++;
    if (obs_stream !== ref_frame(d, 1'b1, 1'b1, o) || obs_nsh != 11) begin
      n_fail++;
      $display("FAIL midload_stream: got %b (%0d shifts) required %b (11 shifts)", obs_stream,
               obs_nsh, ref_frame(d, 1'b1, 1'b1, o));
    end
    n_checks++;
    if (obs_latency != 34 || obs_ld != 1) begin
      n_fail++;
      $display("FAIL midload_timing: got latency %0d ld %0d required 34 and 1", obs_latency,
               obs_ld);
    end
  endtask

  task automatic test_baud_zero();
    int bad;
    run_frame(8'($urandom), 1'b0, 1'b0, 1'b0, 20'd0, -1, 8'h00);
    bad = 0;
    foreach (obs_sh[k]) if (obs_sh[k] != k + 1) bad++;
    n_checks++;
    if (obs_nsh != 11 || bad != 0) begin
      n_fail++;
      $display("FAIL baud0_sh: got %0d pulses %0d misplaced required 11 consecutive", obs_nsh,
               bad);
    end
    n_checks++;
    if (obs_latency != 12) begin
      n_fail++;
      $display("FAIL baud0_latency: got %0d required 12", obs_latency);
    end
  endtask

  task automatic test_load_at_completion();
    // Second write lands exactly on the completion edge and must be dropped.
    run_frame(8'h5A, 1'b1, 1'b0, 1'b0, 20'd1, 22, 8'hC3);
    n_checks++;
    if (obs_post_bad != 0 || obs_ld != 1) begin
      n_fail++;
      $display("FAIL completion_load: got %0d busy cycles after done, ld %0d required 0 and 1",
               obs_post_bad, obs_ld);
    end
    n_checks++;
    if (obs_latency != 23 || obs_int != 1) begin
      n_fail++;
      $display("FAIL completion_timing: got latency %0d int %0d required 23 and 1", obs_latency,
               obs_int);
    end
  endtask

  task automatic test_reset_midframe();
    int   nsh;
    int   quiet_bad;
    logic [7:0] d;
    d        = 8'($urandom);
    baud_k   = 20'd2;
    out_port = d;
    eight    = 1'b1;
    pen      = 1'b0;
    load     = 1'b1;
    tick();
    load = 1'b0;
    nsh  = 0;
    for (int c = 0; c < 100; c++) begin
      if (sh) nsh++;
      if (nsh == 5) break;
      tick();
    end
    n_checks++;
    if (nsh != 5) begin
      n_fail++;
      $display("FAIL rstmid_reach: got %0d shifts required 5", nsh);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({ld, sh, tx_int, tx_rdy} !== 4'b0001 || {din, bit9, bit10} !== 9'b0000000_11) begin
      n_fail++;
      $display("FAIL rstmid_immediate: got ld/sh/int/rdy=%b din=%h b9b10=%b required 0001 00 11",
               {ld, sh, tx_int, tx_rdy}, din, {bit9, bit10});
    end
    tick();
    tick();
    reset     = 1'b0;
    quiet_bad = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (tx_int || sh || ld || !tx_rdy) quiet_bad++;
    end
    n_checks++;
    if (quiet_bad != 0) begin
      n_fail++;
      $display("FAIL rstmid_quiet: got %0d active cycles after reset required 0", quiet_bad);
    end
    run_frame(d, 1'b1, 1'b0, 1'b0, 20'd2, -1, 8'h00);
    n_checks++;
    if (obs_nsh != 11 || obs_stream !== ref_frame(d, 1'b1, 1'b0, 1'b0) || obs_latency != 34) begin
      n_fail++;
      $display("FAIL rstmid_fresh: got %0d shifts stream %b latency %0d required 11 %b 34",
               obs_nsh, obs_stream, obs_latency, ref_frame(d, 1'b1, 1'b0, 1'b0));
    end
  endtask

  task automatic test_random();
    logic [7:0]  d;
    logic        e;
    logic        p;
    logic        o;
    logic [19:0] bk;
    int          bad;
    for (int i = 0; i < 8; i++) begin
      d  = 8'($urandom);
      e  = 1'($urandom);
      p  = 1'($urandom);
      o  = 1'($urandom);
      bk = 20'($urandom_range(0, 5));
      run_frame(d, e, p, o, bk, -1, 8'h00);
      bad = 0;
      foreach (obs_sh[k]) if (obs_sh[k] != (k + 1) * (int'(bk) + 1)) bad++;
      n_checks++;
      if (obs_stream !== ref_frame(d, e, p, o) || obs_nsh != 11 || bad != 0) begin
        n_fail++;
        $display("FAIL random_stream_%0d: d=%h cfg=%b%b%b bk=%0d got %b (%0d shifts, %0d late)",
                 i, d, e, p, o, bk, obs_stream, obs_nsh, bad);
        $display("  required %b", ref_frame(d, e, p, o));
      end
      n_checks++;
      if (obs_latency != 11 * (int'(bk) + 1) + 1 || obs_int != 1) begin
        n_fail++;
        $display("FAIL random_timing_%0d: got latency %0d int %0d required %0d and 1", i,
                 obs_latency, obs_int, 11 * (int'(bk) + 1) + 1);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_idle();
    test_basic_frame();
    test_parity();
    test_midframe_load();
    test_baud_zero();
    test_load_at_completion();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit-side control engine for the UART, directly upstream of the 11-bit TX shift register. It accepts a byte write from the TSI/CPU side and latches data plus frame configuration. It then generates the shift register's load strobe, data bits and bit9/bit10 frame bits, and paces the shift strobe at the programmed baud rate. It reports TX-ready status and a one-cycle completion interrupt back to the host.

Parameters:
- BAUD_W, 20, width of baud terminal-count input and bit-time counter.
- FRAME_BITS, 11, number of shift strobes per frame (must match the shift register length).

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high reset
- load  in  1  write strobe for a new byte, one cycle
- out_port  in  8  byte to transmit
- eight  in  1  1 = 8 data bits, 0 = 7 data bits
- pen  in  1  parity enable
- ohel  in  1  parity sense: 1 = odd, 0 = even
- baud_k  in  BAUD_W  bit-time terminal count; bit period = baud_k+1 clocks
- ld  out  1  shift-register load strobe
- sh  out  1  shift-register shift strobe
- din  out  7  data bits [6:0] to shift register
- bit9  out  1  frame bit 9
- bit10  out  1  frame bit 10
- tx_rdy  out  1  1 = idle, will accept load
- tx_int  out  1  one-cycle pulse on frame completion

Behaviour:
- Reset values: ld=0, sh=0, tx_rdy=1, tx_int=0, doit=0, bit-time counter=0, bit counter=0, data latch=8'h00, latched config=0.
- With data latch 00 and config 0: din=0, bit9=1 (pen=0, eight=0), bit10=1.
- Accept: load=1 while tx_rdy=1, sampled at edge E0. After E0, all of the following hold:
  - out_port, eight, pen and ohel are latched.
  - tx_rdy=0.
  - ld=1 for exactly one cycle.
- A load while tx_rdy=0 is ignored. Latched data and config stay unchanged.
- After E1: ld=0 and doit=1. The shift register is loaded at E1.
- Bit timer, while doit=1:
  - Increments every clock.
  - btu asserts combinationally when timer==baud_k; the timer clears to 0 on the next edge.
  - sh=btu, so each bit period is baud_k+1 clocks.
  - baud_k=0 gives sh high every doit cycle.
- Timer and bit counter hold at 0 while doit=0.
- Bit counter increments on each btu.
- Completion happens on the btu with bit counter == FRAME_BITS-1 (the 11th shift). At that edge:
  - doit, the timer and the bit counter clear.
  - tx_rdy sets to 1.
  - tx_int pulses high for one cycle.
- Latency from the load edge to tx_rdy=1 is 11*(baud_k+1)+1 clocks.
- Frame-bit decode uses latched values only. P = XOR of data bits (8 bits if eight=1, else bits [6:0]), XORed with ohel.
  - eight=1, pen=1: bit9=data[7], bit10=P
  - eight=1, pen=0: bit9=data[7], bit10=1
  - eight=0, pen=1: bit9=P, bit10=1
  - eight=0, pen=0: bit9=1, bit10=1
- din = latched data[6:0].
- Changing config or baud_k inputs mid-frame:
  - Config inputs are ignored until the next accept.
  - baud_k is used live. Software changes it only while tx_rdy=1.
- Load in the same cycle as completion: ignored, because tx_rdy is still 0 in that cycle.
- Reset mid-frame: all state returns to reset values immediately. No tx_int is generated.

Test Plan:
1. Reset then idle -> tx_rdy=1, ld=0, sh=0, tx_int=0. A load with tx_rdy=1 is required for any activity.
2. baud_k=3, eight=1, pen=0, out_port=8'hA5, load at E0:
   - ld high for cycle after E0 only.
   - sh pulses once per 4 clocks; 11 pulses total.
   - Shifted serial stream is 1,0,1,0,1,0,0,1,0,1,1.
   - tx_rdy=1 and tx_int pulse after edge E45.
3. Parity check with out_port=8'h07:
   - eight=1, pen=1, ohel=0 -> bit9=0, bit10=1.
   - ohel=1 -> bit10=0.
   - eight=0, pen=1, ohel=0 -> bit9=1, bit10=1.
4. Second load mid-frame with out_port=8'h3C -> ignored. din/bit9/bit10 are unchanged and the frame completes with the original data.
5. baud_k=0 -> sh asserted on 11 consecutive cycles; tx_rdy returns 12 clocks after the load edge.
6. Assert reset after the 5th sh -> ld/sh/tx_int=0 and tx_rdy=1 immediately. A new load after deassertion starts a fresh 11-shift frame.
